banco_seq: RTL and testbench

- Single-issue command sequencer for the 4x8 register bank (`banco`).
- Accepts one ALU/move command at a time over a valid/ready handshake.
- Drives the bank's two read addresses, computes an 8-bit result and drives the bank's write port.
- Sits between an upstream command source (test FSM or instruction decoder) and `banco`; the bank's own clk/rst are wired at top level.

---
 rtl/banco_seq.sv | 178 +++++++++++++++++
 tb/tb_banco_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/banco_seq.sv
// Single-issue command sequencer for the 4x8 banco register bank.
// Define BANCO_SEQ_FLAGS_EN to add the zero/carry flag outputs.
module banco_seq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src0,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] add_rd0,
  output logic [ADDR_W-1:0] add_rd1,
  input  logic [DATA_W-1:0] rd0,
  input  logic [DATA_W-1:0] rd1,
  output logic [ADDR_W-1:0] add_wr,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
`ifdef BANCO_SEQ_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_c
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W-1:0]   src0_q, src0_d;
  logic [ADDR_W-1:0]   src1_q, src1_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                wr_en_q, wr_en_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   alu_res;
`ifdef BANCO_SEQ_FLAGS_EN
  logic                flag_z_q, flag_z_d;
  logic                flag_c_q, flag_c_d;
`endif

  always_comb begin
    alu_res = '0;
    unique case (op_q)
      OP_MOV:  alu_res = rd0;
      OP_ADD:  alu_res = rd0 + rd1;
      OP_SUB:  alu_res = rd0 - rd1;
      OP_AND:  alu_res = rd0 & rd1;
      OP_OR:   alu_res = rd0 | rd1;
      OP_XOR:  alu_res = rd0 ^ rd1;
      OP_LDI:  alu_res = imm_q;
      OP_NOP:  alu_res = result_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    src0_d   = src0_q;
    src1_d   = src1_q;
    imm_d    = imm_q;
    result_d = result_q;
    wr_en_d  = 1'b0;
    done_d   = 1'b0;
`ifdef BANCO_SEQ_FLAGS_EN
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          dst_d   = cmd_dst;
          src0_d  = cmd_src0;
          src1_d  = cmd_src1;
          imm_d   = cmd_imm;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_q == OP_NOP) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          result_d = alu_res;
          state_d  = S_WRITE;
          wr_en_d  = 1'b1;
`ifdef BANCO_SEQ_FLAGS_EN
          // Wrap-around detection avoids a wider adder for the carry.
          if (op_q inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR}) begin
            flag_z_d = (alu_res == '0);
            flag_c_d = 1'b0;
            if (op_q == OP_ADD) flag_c_d = (alu_res < rd0);
            if (op_q == OP_SUB) flag_c_d = (rd0 < rd1);
          end
`endif
        end
      end
      S_WRITE: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      src0_q   <= '0;
      src1_q   <= '0;
      imm_q    <= '0;
      result_q <= '0;
      wr_en_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef BANCO_SEQ_FLAGS_EN
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      src0_q   <= src0_d;
      src1_q   <= src1_d;
      imm_q    <= imm_d;
      result_q <= result_d;
      wr_en_q  <= wr_en_d;
      done_q   <= done_d;
`ifdef BANCO_SEQ_FLAGS_EN
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
`endif
    end
  end

  assign cmd_ready = rst && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign wr_en     = wr_en_q;
  assign add_rd0   = src0_q;
  assign add_rd1   = src1_q;
  assign add_wr    = dst_q;
  assign wr_data   = result_q;
  assign result    = result_q;
`ifdef BANCO_SEQ_FLAGS_EN
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
`endif

endmodule

// File: tb/tb_banco_seq.sv
// Bench for banco_seq: directed cases plus random commands
// against an array model of the register bank.
module tb_banco_seq;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dst, cmd_src0, cmd_src1;
  logic [7:0] cmd_imm;
  logic [1:0] add_rd0, add_rd1, add_wr;
  logic [7:0] rd0, rd1, wr_data, result;
  logic       wr_en, busy, done;
`ifdef BANCO_SEQ_FLAGS_EN
  logic       flag_z, flag_c;
  logic       exp_z, exp_c;
`endif

  banco_seq dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_src0  (cmd_src0),
    .cmd_src1  (cmd_src1),
    .cmd_imm   (cmd_imm),
    .add_rd0   (add_rd0),
    .add_rd1   (add_rd1),
    .rd0       (rd0),
    .rd1       (rd1),
    .add_wr    (add_wr),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .result    (result)
`ifdef BANCO_SEQ_FLAGS_EN
    ,
    .flag_z    (flag_z),
    .flag_c    (flag_c)
`endif
  );

  logic [7:0] bank [4];
  logic       tb_clr;
  int         mdl [4];
  logic [7:0] exp_res;
  int         n_chk;
  int         n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment bank: written by the DUT, read combinationally.
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 4; i++) bank[i] <= 8'h00;
    end else if (wr_en) begin
      bank[add_wr] <= wr_data;
    end
  end
  assign rd0 = bank[add_rd0];
  assign rd1 = bank[add_rd1];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] ref_alu(input int op, input int a,
                                         input int b, input int imm);
    int r;
    case (op)
      0: r = a;
      1: r = a + b;
      2: r = a - b;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = imm;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  task automatic scramble();
    cmd_op   = 3'($urandom);
    cmd_dst  = 2'($urandom);
    cmd_src0 = 2'($urandom);
    cmd_src1 = 2'($urandom);
    cmd_imm  = 8'($urandom);
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!cmd_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("ready", cmd_ready, 1);
  endtask

  task automatic run_cmd(input int op, input int d, input int s0,
                         input int s1, input int imm, input bit hold);
    int a, b;
    logic [7:0] exp;
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_dst   = 2'(d);
    cmd_src0  = 2'(s0);
    cmd_src1  = 2'(s1);
    cmd_imm   = 8'(imm);
    wait_ready();
    a = mdl[s0];
    b = mdl[s1];
    exp = ref_alu(op, a, b, imm);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    scramble();
    check("exec_busy", busy, 1);
    check("exec_wr", wr_en, 0);
    check("exec_rdy", cmd_ready, 0);
    @(negedge clk);
    if (op != 7) begin
      check("wr_en", wr_en, 1);
      check("add_wr", add_wr, d);
      check("wr_data", wr_data, exp);
      check("wr_done", done, 0);
      @(negedge clk);
    end else begin
      check("nop_wr", wr_en, 0);
    end
    check("done", done, 1);
    check("done_rdy", cmd_ready, 0);
    if (op != 7) begin
      mdl[d] = exp;
      exp_res = exp;
    end
`ifdef BANCO_SEQ_FLAGS_EN
    if (op >= 1 && op <= 5) begin
      exp_z = (exp == 0);
      exp_c = (op == 1) ? (a + b > 255) : (op == 2) ? (a < b) : 1'b0;
    end
`endif
    @(negedge clk);
    check("done_off", done, 0);
    check("idle_rdy", cmd_ready, 1);
    check("result", result, exp_res);
    check("bank", bank[d], mdl[d]);
`ifdef BANCO_SEQ_FLAGS_EN
    check("flag_z", flag_z, exp_z);
    check("flag_c", flag_c, exp_c);
`endif
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    exp_res = 8'h00;
    for (int i = 0; i < 4; i++) mdl[i] = 0;
`ifdef BANCO_SEQ_FLAGS_EN
    exp_z = 1'b0;
    exp_c = 1'b0;
`endif
    tb_clr = 1'b1;
    rst = 1'b0;
    cmd_valid = 1'b1;
    scramble();
    @(negedge clk);
    @(negedge clk);
    check("rst_rdy", cmd_ready, 0);
    check("rst_wr", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", result, 0);
    tb_clr = 1'b0;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rel_rdy", cmd_ready, 1);
    check("rel_busy", busy, 0);

    run_cmd(6, 2, 0, 0, 8'hA5, 0);
    run_cmd(6, 0, 0, 0, 8'hF0, 0);
    run_cmd(6, 1, 0, 0, 8'h20, 0);
    run_cmd(1, 3, 0, 1, 0, 0);
    check("add_wrap", bank[3], 8'h10);
    run_cmd(2, 3, 1, 0, 0, 0);
    check("sub_wrap", bank[3], 8'h30);
    run_cmd(7, 0, 1, 2, 0, 1);
    run_cmd(6, 1, 0, 0, 8'h07, 0);
    run_cmd(1, 1, 1, 1, 0, 0);
    run_cmd(1, 1, 1, 1, 0, 0);
    check("same_reg", bank[1], 8'h1C);

    for (int n = 0; n < 60; n++) begin
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;
    @(negedge clk);

    // Abort in EXEC: nothing written, no done.
    cmd_valid = 1'b1;
    cmd_op = 3'd1;
    cmd_dst = 2'd2;
    cmd_src0 = 2'd0;
    cmd_src1 = 2'd1;
    wait_ready();
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("abx_wr", wr_en, 0);
    check("abx_done", done, 0);
    check("abx_busy", busy, 0);
    check("abx_rdy", cmd_ready, 0);
    exp_res = 8'h00;
`ifdef BANCO_SEQ_FLAGS_EN
    exp_z = 1'b0;
    exp_c = 1'b0;
    check("abx_z", flag_z, exp_z);
    check("abx_c", flag_c, exp_c);
`endif
    check("abx_res", result, exp_res);
    rst = 1'b1;
    @(negedge clk);
    check("abx_rdy2", cmd_ready, 1);
    check("abx_done2", done, 0);
    check("abx_bank", bank[2], mdl[2]);

    // Abort in WRITE: the write at that edge still lands.
    cmd_valid = 1'b1;
    cmd_op = 3'd6;
    cmd_dst = 2'd3;
    cmd_imm = 8'h5A;
    wait_ready();
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("abw_wr", wr_en, 1);
    rst = 1'b0;
    mdl[3] = 8'h5A;
    @(negedge clk);
    check("abw_wr0", wr_en, 0);
    check("abw_done", done, 0);
    check("abw_bank", bank[3], mdl[3]);
    rst = 1'b1;
    @(negedge clk);
    check("abw_done2", done, 0);
    check("abw_res", result, 8'h00);
    check("abw_rdy", cmd_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
